sdram_ctrl: RTL and testbench

SDRAM_CTRL -- requirements
Module: sdram_ctrl

---
 rtl/sdram_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sdram_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_ctrl.sv
// Single-access SDRAM controller: init sequence, periodic auto-refresh, and one
// ACT -> READ/WRITE (auto-precharge) per request. `SDRAM_BYTE_WMASK_EN adds byte write masks.
module sdram_ctrl #(
  parameter int T_INIT = 10000,
  parameter int T_RP   = 2,
  parameter int T_RCD  = 2,
  parameter int T_RFC  = 7,
  parameter int T_REFI = 750,
  parameter int T_WREC = 4,
  parameter int CAS    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
`ifdef SDRAM_BYTE_WMASK_EN
  input  logic [1:0]  req_wmask,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        sdram_cle,
  output logic        sdram_cs,
  output logic        sdram_ras,
  output logic        sdram_cas,
  output logic        sdram_we,
  output logic [1:0]  sdram_dqm,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_a,
  inout  wire  [15:0] sdram_dq
);
  localparam logic [3:0] CMD_NOP = 4'b0111, CMD_ACT = 4'b0011, CMD_RD  = 4'b0101,
                         CMD_WR  = 4'b0100, CMD_PRE = 4'b0010, CMD_REF = 4'b0001,
                         CMD_MRS = 4'b0000;
  localparam logic [12:0] MRS_A = (CAS == 3) ? 13'h030 : 13'h020;

  typedef enum logic [3:0] {
    INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS,
    IDLE, REFRESH, ACTIVATE, RW, RD_WAIT, RECOVER
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] ref_cnt;
  logic        ref_pending, init_done;
  logic        rw_q;
  logic [23:0] addr_q;
  logic [15:0] wdata_q;
  logic [3:0]  cmd;
  logic        dq_oe;
  logic [15:0] dq_out;
`ifdef SDRAM_BYTE_WMASK_EN
  logic [1:0]  wmask_q;
`endif

  assign {sdram_cs, sdram_ras, sdram_cas, sdram_we} = cmd;
  assign sdram_dq  = dq_oe ? dq_out : 16'hzzzz;
  assign req_ready = (state == IDLE) && !ref_pending;

  // Every timed state fires its next command on the edge where cnt reads 1,
  // so loading cnt with N puts the next command exactly N cycles later.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= INIT_WAIT;
      cnt         <= 16'(T_INIT);
      sdram_cle   <= 1'b0;
      cmd         <= CMD_NOP;
      sdram_ba    <= 2'b00;
      sdram_a     <= 13'h0;
      sdram_dqm   <= 2'b11;
      dq_oe       <= 1'b0;
      dq_out      <= 16'h0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 16'h0;
      ref_pending <= 1'b0;
      ref_cnt     <= 16'h0;
      init_done   <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= 24'h0;
      wdata_q     <= 16'h0;
`ifdef SDRAM_BYTE_WMASK_EN
      wmask_q     <= 2'b00;
`endif
    end else begin
      sdram_cle <= 1'b1;
      cmd       <= CMD_NOP;
      sdram_dqm <= 2'b00;
      dq_oe     <= 1'b0;
      rsp_valid <= 1'b0;
      if (cnt != 16'd0) cnt <= cnt - 16'd1;

      case (state)
        INIT_WAIT: if (cnt == 16'd1) begin
          cmd <= CMD_PRE; sdram_a <= 13'h0400; state <= INIT_PRE; cnt <= 16'(T_RP);
        end
        INIT_PRE: if (cnt == 16'd1) begin
          cmd <= CMD_REF; state <= INIT_REF1; cnt <= 16'(T_RFC);
        end
        INIT_REF1: if (cnt == 16'd1) begin
          cmd <= CMD_REF; state <= INIT_REF2; cnt <= 16'(T_RFC);
        end
        INIT_REF2: if (cnt == 16'd1) begin
          cmd <= CMD_MRS; sdram_ba <= 2'b00; sdram_a <= MRS_A; state <= INIT_MRS; cnt <= 16'd2;
        end
        INIT_MRS: if (cnt == 16'd1) begin
          state <= IDLE; init_done <= 1'b1; ref_cnt <= 16'h0;
        end
        IDLE: begin
          if (ref_pending) begin
            cmd <= CMD_REF; ref_pending <= 1'b0; state <= REFRESH; cnt <= 16'(T_RFC);
          end else if (req_valid) begin
            rw_q     <= req_rw;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
`ifdef SDRAM_BYTE_WMASK_EN
            wmask_q  <= req_wmask;
`endif
            cmd      <= CMD_ACT;
            sdram_ba <= req_addr[23:22];
            sdram_a  <= req_addr[21:9];
            state    <= ACTIVATE;
            cnt      <= 16'(T_RCD);
          end
        end
        REFRESH: if (cnt == 16'd1) state <= IDLE;
        ACTIVATE: if (cnt == 16'd1) begin
          cmd      <= rw_q ? CMD_WR : CMD_RD;
          sdram_ba <= addr_q[23:22];
          sdram_a  <= {2'b00, 1'b1, 1'b0, addr_q[8:0]};
          state    <= RW;
          if (rw_q) begin
            dq_oe  <= 1'b1;
            dq_out <= wdata_q;
`ifdef SDRAM_BYTE_WMASK_EN
            sdram_dqm <= ~wmask_q;
`endif
          end
        end
        RW: begin
          state <= rw_q ? RECOVER : RD_WAIT;
          cnt   <= rw_q ? 16'(T_WREC) : 16'(CAS);
        end
        RD_WAIT: if (cnt == 16'd1) begin
          rsp_valid <= 1'b1; rsp_rdata <= sdram_dq; state <= RECOVER; cnt <= 16'(T_WREC);
        end
        RECOVER: if (cnt == 16'd1) state <= IDLE;
        default: state <= INIT_WAIT;
      endcase

      // Placed after the FSM so a tick coinciding with a REF issue is not lost.
      if (init_done) begin
        if (ref_cnt == 16'(T_REFI - 1)) begin
          ref_cnt     <= 16'h0;
          ref_pending <= 1'b1;
        end else begin
          ref_cnt <= ref_cnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sdram_ctrl.sv
// Bench for sdram_ctrl: init/refresh timing windows, directed and random accesses
// against a scoreboard memory, plus a small SDRAM device model on the dq bus.
module tb_sdram_ctrl;
  localparam int T_INIT = 50, T_RP = 2, T_RCD = 2, T_RFC = 7, T_REFI = 200, T_WREC = 4, CAS = 2;
  localparam int MAXLAT = 20;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101, C_WR = 4'b0100,
                         C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;
  localparam logic [15:0] DQ_IDLE = 16'hFFFF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid, req_ready, req_rw, rsp_valid;
  logic [23:0] req_addr;
  logic [15:0] req_wdata, rsp_rdata;
  logic [1:0]  wmask;
  logic        sdram_cle, sdram_cs, sdram_ras, sdram_cas, sdram_we;
  logic [1:0]  sdram_dqm, sdram_ba;
  logic [12:0] sdram_a;
  wire  [15:0] sdram_dq;

  always #5 clock = ~clock;

  sdram_ctrl #(.T_INIT(T_INIT), .T_RP(T_RP), .T_RCD(T_RCD), .T_RFC(T_RFC),
               .T_REFI(T_REFI), .T_WREC(T_WREC), .CAS(CAS)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SDRAM_BYTE_WMASK_EN
    .req_wmask(wmask),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sdram_cle(sdram_cle), .sdram_cs(sdram_cs), .sdram_ras(sdram_ras),
    .sdram_cas(sdram_cas), .sdram_we(sdram_we), .sdram_dqm(sdram_dqm),
    .sdram_ba(sdram_ba), .sdram_a(sdram_a), .sdram_dq(sdram_dq)
  );

  // Undriven bus floats high, so "released" reads as DQ_IDLE.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (sdram_dq[i]);
  end

  // Device model: row per bank on ACT, masked writes, read data valid CAS edges after READ.
  logic        dev_oe = 1'b0;
  logic [15:0] dev_dq = 16'h0;
  logic [15:0] dev_mem [int];
  logic [12:0] open_row [4];
  int          rd_cnt = 0;
  assign sdram_dq = dev_oe ? dev_dq : 16'hzzzz;

  always @(posedge clock) begin : dev
    logic [3:0]  c;
    logic [15:0] w;
    int          key;
    c = {sdram_cs, sdram_ras, sdram_cas, sdram_we};
    if (rd_cnt > 0) rd_cnt--;
    if (sdram_cle) begin
      if (c == C_ACT) open_row[sdram_ba] = sdram_a;
      key = int'({sdram_ba, open_row[sdram_ba], sdram_a[8:0]});
      if (c == C_WR) begin
        w = dev_mem.exists(key) ? dev_mem[key] : 16'h0;
        if (!sdram_dqm[0]) w[7:0]  = sdram_dq[7:0];
        if (!sdram_dqm[1]) w[15:8] = sdram_dq[15:8];
        dev_mem[key] = w;
      end
      if (c == C_RD) begin
        dev_dq = dev_mem.exists(key) ? dev_mem[key] : 16'h0;
        rd_cnt = CAS;
      end
    end
    #1;
    dev_oe = (rd_cnt == 1);
  end

  int          cyc = 0, n_cmp = 0, n_err = 0, nref = 0, d_cyc = 0, last_ref = -1000;
  bit          ref_on = 0, rsp_exp = 0, dq_exp_en = 0;
  logic [15:0] dq_exp = 16'h0;
  logic [3:0]  cmd = C_NOP;
  logic [15:0] ref_mem [int];
  logic [23:0] pool [8];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // One observation per cycle, half a period after the active edge.
  task automatic tick();
    int lo;
    @(negedge clock);
    cyc++;
    cmd = {sdram_cs, sdram_ras, sdram_cas, sdram_we};
    chk("rsp_v", rsp_valid, rsp_exp);
    if (dq_exp_en)   chk("wr_dq", sdram_dq, dq_exp);
    else if (!dev_oe) chk("dq_rel", sdram_dq, DQ_IDLE);
    if (ref_on && cmd == C_REF) begin
      nref++;
      lo = d_cyc + nref * T_REFI + 1;
      chk("ref_win", (cyc >= lo) && (cyc <= lo + MAXLAT), 1);
      chk("ref_rdy", req_ready, 0);
      last_ref = cyc;
    end
    if (ref_on && cmd == C_ACT) chk("rfc_gap", (cyc - last_ref) > T_RFC, 1);
  endtask

  task automatic wait_cmd(input int bound, output int t);
    int n;
    n = 0;
    tick();
    while (cmd == C_NOP && n < bound) begin tick(); n++; end
    chk("cmd_wait", n < bound, 1);
    t = cyc;
  endtask

  task automatic init_seq();
    int rel, t, tp;
    ref_on  = 0;
    nref    = 0;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_cle", sdram_cle, 0);
    chk("rst_cmd", cmd, C_NOP);
    chk("rst_dqm", sdram_dqm, 2'b11);
    chk("rst_ba", sdram_ba, 0);
    chk("rst_a", sdram_a, 0);
    chk("rst_rdy", req_ready, 0);
    chk("rst_rdata", rsp_rdata, 0);
    reset_n = 1'b1;
    rel = cyc;
    tick();
    chk("cle_up", sdram_cle, 1);
    wait_cmd(T_INIT + 5, t);
    chk("pre_cmd", cmd, C_PRE); chk("pre_t", t - rel, T_INIT); chk("pre_a10", sdram_a[10], 1);
    tp = t; wait_cmd(T_RFC + 5, t);
    chk("ref1_cmd", cmd, C_REF); chk("ref1_t", t - tp, T_RP);
    tp = t; wait_cmd(T_RFC + 5, t);
    chk("ref2_cmd", cmd, C_REF); chk("ref2_t", t - tp, T_RFC);
    tp = t; wait_cmd(T_RFC + 5, t);
    chk("mrs_cmd", cmd, C_MRS); chk("mrs_t", t - tp, T_RFC);
    chk("mrs_a", sdram_a, (CAS == 3) ? 13'h030 : 13'h020); chk("mrs_ba", sdram_ba, 0);
    tp = t;
    while (!req_ready && cyc - tp < 10) tick();
    chk("rdy_first", cyc - tp, 2);
    d_cyc    = cyc;
    last_ref = -1000;
    ref_on   = 1;
  endtask

  task automatic do_req(input bit rw, input logic [23:0] addr, input logic [15:0] wd,
                        input logic [1:0] mk, input bit expect_ref);
    int          n0, w, key;
    logic [15:0] v;
    logic [1:0]  exp_dqm;
    key = int'(addr);
    req_rw = rw; req_addr = addr; req_wdata = wd; wmask = mk; req_valid = 1'b1;
    n0 = nref; w = 0;
    while (!req_ready && w < 500) begin tick(); w++; end
    chk("rdy_wait", req_ready, 1);
    if (!req_ready) begin req_valid = 1'b0; return; end
    tick();
    req_valid = 1'b0;
    chk("act_cmd", cmd, C_ACT);
    chk("act_ba", sdram_ba, 2'(addr / (1 << 22)));
    chk("act_row", sdram_a, 13'((addr / 512) % 8192));
    if (expect_ref) chk("ref_first", nref - n0, 1);
    for (int i = 1; i < T_RCD; i++) begin tick(); chk("rcd_nop", cmd, C_NOP); end
    dq_exp_en = rw; dq_exp = wd;
    tick();
    dq_exp_en = 0;
    chk("rw_cmd", cmd, rw ? C_WR : C_RD);
    chk("rw_ba", sdram_ba, 2'(addr / (1 << 22)));
    chk("rw_a", sdram_a, 13'h400 + 13'(addr % 512));
    v = ref_mem.exists(key) ? ref_mem[key] : 16'h0;
    if (rw) begin
`ifdef SDRAM_BYTE_WMASK_EN
      exp_dqm = ~mk;
      if (mk[0]) v[7:0]  = wd[7:0];
      if (mk[1]) v[15:8] = wd[15:8];
`else
      exp_dqm = 2'b00;
      v = wd;
`endif
      chk("wr_dqm", sdram_dqm, exp_dqm);
      ref_mem[key] = v;
      tick();
    end else begin
      chk("rd_dqm", sdram_dqm, 2'b00);
      repeat (CAS) tick();
      rsp_exp = 1;
      tick();
      rsp_exp = 0;
      chk("rd_data", rsp_rdata, v);
      tick();
    end
  endtask

  initial begin
    int tgt, k;
    req_valid = 0; req_rw = 0; req_addr = 0; req_wdata = 0; wmask = 2'b11;
    init_seq();

    do_req(1, 24'h40_1203, 16'hBEEF, 2'b11, 0);
    do_req(0, 24'h40_1203, 16'h0, 2'b11, 0);
    chk("beef", rsp_rdata, 16'hBEEF);
`ifdef SDRAM_BYTE_WMASK_EN
    do_req(1, 24'h40_1203, 16'h1234, 2'b01, 0);
    do_req(0, 24'h40_1203, 16'h0, 2'b11, 0);
    chk("bmask", rsp_rdata, 16'hBE34);
`endif

    // Request held across a refresh tick: REF must go first.
    tgt = d_cyc + ((cyc - d_cyc) / T_REFI + 1) * T_REFI;
    if (tgt - cyc < 10) tgt += T_REFI;
    while (cyc < tgt - 1) tick();
    chk("rdy_pre", req_ready, 1);
    tick();
    chk("rdy_pend", req_ready, 0);
    do_req(0, 24'h40_1203, 16'h0, 2'b11, 1);

    for (int i = 0; i < 8; i++) pool[i] = 24'($urandom);
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 7);
      do_req(1'($urandom_range(0, 1)), pool[k], 16'($urandom), 2'($urandom), 0);
      repeat ($urandom_range(0, 4)) tick();
    end

    tgt = d_cyc + ((cyc - d_cyc) / T_REFI + 1) * T_REFI + T_REFI / 2;
    while (cyc < tgt) tick();
    chk("ref_count", nref, (tgt - d_cyc) / T_REFI);

    // Reset between ACT and READ: no response, full init again.
    req_rw = 0; req_addr = pool[0]; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 500) begin tick(); k++; end
    tick();
    req_valid = 1'b0;
    chk("mid_act", cmd, C_ACT);
    init_seq();
    repeat (20) tick();
    do_req(1, 24'h00_0010, 16'h5A5A, 2'b11, 0);
    do_req(0, 24'h00_0010, 16'h0, 2'b11, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
